// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and helpers for the reset sequencer
// Purpose : sequencer state encoding, reset-cause encoding and the counter
//           width helper used by the sequencer and its debouncer.
// Ports   : none (package).
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_POWER = 2'd1,
        CAUSE_SW    = 2'd2
    } cause_e;

    // Width that holds the largest terminal count without wrapping.
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_if.sv
// rtl/reset_seq_if.sv - power/request inputs and domain reset outputs
// Purpose : bundles the sequencer's functional signals.
// Signals : power (raw power-good), req_n (per-domain sw reset request),
//           dom_rst_n (per-domain reset), ready (all released), cause.
// Modports: master drives power/req_n, slave is the sequencer.
interface reset_seq_if #(
    parameter int NumDomains = 3
);
    import reset_seq_pkg::*;

    logic                  power;
    logic [NumDomains-1:0] req_n;
    logic [NumDomains-1:0] dom_rst_n;
    logic                  ready;
    cause_e                cause;

    modport master (
        output power,
        output req_n,
        input  dom_rst_n,
        input  ready,
        input  cause
    );

    modport slave (
        input  power,
        input  req_n,
        output dom_rst_n,
        output ready,
        output cause
    );

endinterface

// File: rtl/reset_seq_sync_debounce.sv
// rtl/reset_seq_sync_debounce.sv - two-flop synchroniser plus debouncer
// Purpose : brings an asynchronous level into clk and filters glitches.
// Ports   : clk, rst_n (sync active-low), in (async level), out (debounced).
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int Cycles = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int CntW = cnt_width(Cycles, Cycles, Cycles);
    localparam logic [CntW-1:0] CntTerm = CntW'(Cycles);

    logic [1:0]      sync_q;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // The counter climbs while the synchronised level disagrees with the
    // debounced one; the edge that finds it at the terminal count flips
    // the output, so any agreeing sample in between restarts the wait.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CntTerm) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], in};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out = db_q;

endmodule

// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - ordered multi-domain reset sequencer
// Purpose : holds all domains in reset until debounced power has been good
//           for HoldCycles, then releases domain 0..NumDomains-1 spaced by
//           StageCycles; software requests re-reset a domain and dependants.
// Ports   : clk, rst_n (sync active-low), bus (reset_seq_if.slave:
//           power, req_n in; dom_rst_n, ready, cause out).
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NumDomains     = 3,
    parameter int DebounceCycles = 16,
    parameter int HoldCycles     = 32,
    parameter int StageCycles    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    reset_seq_if.slave     bus
);

    localparam int CntW = cnt_width(DebounceCycles, HoldCycles, StageCycles);
    localparam int IdxW = $clog2(NumDomains + 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] StageLast = CntW'(StageCycles - 1);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumDomains - 1);

    logic pwr_db;

    sync_debounce #(
        .Cycles (DebounceCycles)
    ) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (bus.power),
        .out   (pwr_db)
    );

    state_e                state_q, state_d;
    logic [NumDomains-1:0] dom_q, dom_d;
    logic                  ready_q, ready_d;
    cause_e                cause_q, cause_d;
    logic [CntW-1:0]       hold_q, hold_d;
    logic [CntW-1:0]       stage_q, stage_d;
    // Next domain to release; in SW_HOLD, the lowest asserted domain.
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NumDomains-1:0] req_q;

    logic            req_any;
    logic [IdxW-1:0] req_idx;
    logic            rel_en;
    logic [IdxW-1:0] rel_idx;
    logic            clr_en;
    logic [IdxW-1:0] clr_from;

    always_comb begin
        req_any = ~&req_q;
        req_idx = '0;
        for (int i = NumDomains - 1; i >= 0; i--) begin
            if (!req_q[i]) req_idx = IdxW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        dom_d    = dom_q;
        ready_d  = ready_q;
        cause_d  = cause_q;
        hold_d   = hold_q;
        stage_d  = stage_q;
        idx_d    = idx_q;
        rel_en   = 1'b0;
        rel_idx  = idx_q;
        clr_en   = 1'b0;
        clr_from = idx_q;

        case (state_q)
            ASSERT: begin
                if (hold_q == HoldLast) begin
                    rel_en  = 1'b1;
                    rel_idx = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (req_any) begin
                    // Domains at or above idx are still held; never
                    // re-release above the lowest one already asserted.
                    clr_en   = 1'b1;
                    clr_from = (req_idx < idx_q) ? req_idx : idx_q;
                    idx_d    = clr_from;
                    state_d  = SW_HOLD;
                    ready_d  = 1'b0;
                    cause_d  = CAUSE_SW;
                    hold_d   = '0;
                    stage_d  = '0;
                end else if (state_q == RELEASE) begin
                    if (stage_q == StageLast) begin
                        rel_en = 1'b1;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            SW_HOLD: begin
                if (req_any) begin
                    clr_en   = 1'b1;
                    clr_from = (req_idx < idx_q) ? req_idx : idx_q;
                    idx_d    = clr_from;
                    hold_d   = '0;
                end else if (hold_q == HoldLast) begin
                    rel_en = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        if (clr_en) begin
            for (int i = 0; i < NumDomains; i++) begin
                if (i >= int'(clr_from)) dom_d[i] = 1'b0;
            end
        end

        // Releasing the last domain goes straight to RUN, which also covers
        // the single-domain case leaving ASSERT.
        if (rel_en) begin
            for (int i = 0; i < NumDomains; i++) begin
                if (i == int'(rel_idx)) dom_d[i] = 1'b1;
            end
            idx_d   = rel_idx + 1'b1;
            hold_d  = '0;
            stage_d = '0;
            if (rel_idx == LastIdx) begin
                ready_d = 1'b1;
                state_d = RUN;
            end else begin
                state_d = RELEASE;
            end
        end

        // Power loss overrides everything, including a same-edge request.
        if (!pwr_db) begin
            state_d = ASSERT;
            dom_d   = '0;
            ready_d = 1'b0;
            cause_d = CAUSE_POWER;
            hold_d  = '0;
            stage_d = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ASSERT;
            dom_q   <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POWER;
            hold_q  <= '0;
            stage_q <= '0;
            idx_q   <= '0;
            req_q   <= '1;
        end else begin
            state_q <= state_d;
            dom_q   <= dom_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
            hold_q  <= hold_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            // Requests sampled while everything is held are dropped.
            req_q   <= (state_q == ASSERT) ? '1 : bus.req_n;
        end
    end

    assign bus.dom_rst_n = dom_q;
    assign bus.ready     = ready_q;
    assign bus.cause     = cause_q;

endmodule
